// File: rtl/lcd_pkg.sv
// Segment patterns shared by the BCD-to-7seg encoder and the LCD readback decoder.
// Bit map: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
package lcd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_ERR   = 7'b0111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Encoder-side lookup; out-of-range digits show the error glyph.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_seg_decoder_if.sv
// LCD pin side and decoded-result side of the readback receiver.
interface lcd_seg_decoder_if;
    logic       lcd_bp;
    logic [6:0] lcd_seg;
    logic [3:0] bcd_out;
    logic       valid;
    logic       err;
    logic       update;
    logic       bp_lost;

    modport master (
        output lcd_bp, lcd_seg,
        input  bcd_out, valid, err, update, bp_lost
    );

    modport slave (
        input  lcd_bp, lcd_seg,
        output bcd_out, valid, err, update, bp_lost
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD digit; legal is low for any non-digit pattern.
module seg7_to_bcd
    import lcd_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_seg_decoder.sv
// AC-LCD digit readback: synchronise pins, demodulate against the backplane,
// debounce over STABLE_FRAMES half-periods and decode to BCD.
module lcd_seg_decoder
    import lcd_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int BP_TIMEOUT    = 64
) (
    input  logic               osc_sclk,
    input  logic               rst,
    lcd_seg_decoder_if.slave   bus
);

    localparam logic [3:0] SF_C = 4'(STABLE_FRAMES);
    localparam logic [6:0] TO_C = 7'(BP_TIMEOUT);

    logic       bp_meta_reg, bp_sync_reg, bp_prev_reg;
    logic [6:0] seg_meta_reg, seg_sync_reg, seg_prev_reg;
    logic [6:0] pat_reg, pat_next;
    logic [3:0] count_reg, count_next;
    logic       accept_reg, accept_next;
    logic [6:0] to_cnt_reg, to_cnt_next;
    logic [3:0] bcd_reg, bcd_next;
    logic       valid_reg, valid_next;
    logic       err_reg, err_next;
    logic       update_reg, update_next;
    logic       bp_lost_reg, bp_lost_next;

    logic       bp_edge;
    logic       timeout_hit;
    logic       same;
    logic [6:0] pattern;
    logic [3:0] digit;
    logic       legal;

    // Lit segments are driven opposite to the backplane; sample the phase just completed.
    for (genvar gi = 0; gi < 7; gi++) begin : g_demod
        assign pattern[gi] = seg_prev_reg[gi] ^ bp_prev_reg;
    end

    assign bp_edge     = bp_sync_reg ^ bp_prev_reg;
    assign same        = (pattern == pat_reg);
    assign timeout_hit = !bp_edge && (to_cnt_next == TO_C);

    seg7_to_bcd u_dec (
        .pattern (pat_reg),
        .digit   (digit),
        .legal   (legal)
    );

    always_comb begin
        pat_next     = pat_reg;
        count_next   = count_reg;
        accept_next  = 1'b0;
        to_cnt_next  = to_cnt_reg;
        bcd_next     = bcd_reg;
        valid_next   = valid_reg;
        err_next     = err_reg;
        bp_lost_next = bp_lost_reg;

        if (bp_edge)
            to_cnt_next = 7'd0;
        else if (to_cnt_reg != TO_C)
            to_cnt_next = to_cnt_reg + 7'd1;

        if (bp_edge) begin
            if (same) begin
                count_next = (count_reg >= SF_C) ? SF_C : count_reg + 4'd1;
            end else begin
                count_next = 4'd1;
                pat_next   = pattern;
            end
            // Accept only on the transition into saturation, not while it holds.
            accept_next  = (count_next == SF_C) && !(same && count_reg == SF_C);
            bp_lost_next = 1'b0;
        end else if (timeout_hit) begin
            count_next   = 4'd0;
            bp_lost_next = 1'b1;
        end

        // pat_reg now holds the pattern that was just accepted.
        if (accept_reg) begin
            if (legal) begin
                bcd_next   = digit;
                valid_next = 1'b1;
                err_next   = 1'b0;
            end else begin
                valid_next = 1'b0;
                err_next   = 1'b1;
            end
        end
        if (timeout_hit)
            valid_next = 1'b0;

        update_next = ({bcd_next, valid_next, err_next} != {bcd_reg, valid_reg, err_reg});
    end

    always_ff @(posedge osc_sclk or posedge rst) begin
        if (rst) begin
            bp_meta_reg  <= 1'b0;
            bp_sync_reg  <= 1'b0;
            bp_prev_reg  <= 1'b0;
            seg_meta_reg <= 7'd0;
            seg_sync_reg <= 7'd0;
            seg_prev_reg <= 7'd0;
            pat_reg      <= 7'd0;
            count_reg    <= 4'd0;
            accept_reg   <= 1'b0;
            to_cnt_reg   <= 7'd0;
            bcd_reg      <= 4'd0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            update_reg   <= 1'b0;
            bp_lost_reg  <= 1'b1;
        end else begin
            bp_meta_reg  <= bus.lcd_bp;
            bp_sync_reg  <= bp_meta_reg;
            bp_prev_reg  <= bp_sync_reg;
            seg_meta_reg <= bus.lcd_seg;
            seg_sync_reg <= seg_meta_reg;
            seg_prev_reg <= seg_sync_reg;
            pat_reg      <= pat_next;
            count_reg    <= count_next;
            accept_reg   <= accept_next;
            to_cnt_reg   <= to_cnt_next;
            bcd_reg      <= bcd_next;
            valid_reg    <= valid_next;
            err_reg      <= err_next;
            update_reg   <= update_next;
            bp_lost_reg  <= bp_lost_next;
        end
    end

    assign bus.bcd_out = bcd_reg;
    assign bus.valid   = valid_reg;
    assign bus.err     = err_reg;
    assign bus.update  = update_reg;
    assign bus.bp_lost = bp_lost_reg;

endmodule
